// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle CPU control FSM with memory-ready handshake, timeout and illegal-opcode trap.
// Optional macro PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        branch_eq_o,
  output logic [1:0]  pc_source_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [3:0]  state_o,
`ifdef PERF_CNT_EN
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retire_cnt_o,
`endif
  output logic        fault_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          state, state_nxt;
  logic [5:0]      op_q;
  logic [TO_W-1:0] to_cnt, to_cnt_inc;
  logic            waiting, to_hit;

  // The three states that stall on the memory handshake share one timeout counter.
  assign waiting    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign to_cnt_inc = to_cnt + 1'b1;
  assign to_hit     = (MEM_TIMEOUT != 0) && waiting && !mem_ready_i && (to_cnt_inc == TO_LIMIT);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready_i) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_R:            state_nxt = S_REXE;
          OP_LW, OP_SW:    state_nxt = S_MEMADR;
          OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
          OP_J:            state_nxt = S_JUMP;
          OP_ADDI, OP_SLTI: state_nxt = S_IEXE;
          default:         state_nxt = S_HALT;
        endcase
      end
      S_MEMADR: state_nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  if (mem_ready_i) state_nxt = S_FETCH;
      S_REXE:   state_nxt = S_RWB;
      S_RWB:    state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_IEXE:   state_nxt = S_IWB;
      S_IWB:    state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
    // Timeout only fires on a not-ready cycle, so a same-cycle ready always wins.
    if (to_hit) state_nxt = S_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_FETCH;
      op_q   <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= opcode_i;
      if (waiting && !mem_ready_i && !to_hit) to_cnt <= to_cnt_inc;
      else                                    to_cnt <= '0;
    end
  end

  // Outputs decode the current state (plus mem_ready_i in FETCH), so reset reaches them without a clock edge.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_eq_o     = 1'b0;
    pc_source_o     = 2'd0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_op_o        = 3'd0;
    fault_o         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
        end
      end
      S_DECODE: alu_src_b_o = 2'd3;
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_REXE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'd2;
      end
      S_RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 3'd1;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'd1;
        branch_eq_o     = (op_q == OP_BEQ);
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'd2;
      end
      S_IEXE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = (op_q == OP_SLTI) ? 3'd3 : 3'd0;
      end
      S_IWB:  reg_write_o = 1'b1;
      S_HALT: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_o  <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (state != S_FETCH && state_nxt == S_FETCH) retire_cnt_o <= retire_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction streams checked against a transaction-level model of the
// expected state trace and a per-state output table.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, REXE = 4'd6, RWB = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, IEXE = 4'd10, IWB = 4'd11, HALT = 4'd15;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_eq;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       fault;
  } out_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] drv_op;
    logic [5:0] op;
    bit         rst_mid;
  } step_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, branch_eq_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, fault_o;
  logic [1:0] pc_source_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int    n_vec = 0;
  int    n_err = 0;
  step_t q[$];

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_eq_o(branch_eq_o),
    .pc_source_o(pc_source_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .state_o(state_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected datapath controls for one state, straight from the control table.
  function automatic out_t exp_out(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    out_t o;
    o = '0;
    case (st)
      FETCH: begin
        o.mem_read = 1'b1; o.alu_src_b = 2'd1;
        if (rdy) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
      end
      DECODE: o.alu_src_b = 2'd3;
      MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
      MEMRD:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      MEMWB:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      MEMWR:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      REXE:   begin o.alu_src_a = 1'b1; o.alu_op = 3'd2; end
      RWB:    begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      BRANCH: begin
        o.alu_src_a = 1'b1; o.alu_op = 3'd1; o.pc_write_cond = 1'b1; o.pc_source = 2'd1;
        o.branch_eq = (op == 6'h04);
      end
      JUMP:   begin o.pc_write = 1'b1; o.pc_source = 2'd2; end
      IEXE:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = (op == 6'h0A) ? 3'd3 : 3'd0; end
      IWB:    o.reg_write = 1'b1;
      HALT:   o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t obs();
    out_t o;
    o.pc_write = pc_write_o;   o.pc_write_cond = pc_write_cond_o; o.branch_eq = branch_eq_o;
    o.pc_source = pc_source_o; o.i_or_d = i_or_d_o;               o.mem_read = mem_read_o;
    o.mem_write = mem_write_o; o.ir_write = ir_write_o;           o.reg_write = reg_write_o;
    o.reg_dst = reg_dst_o;     o.mem_to_reg = mem_to_reg_o;       o.alu_src_a = alu_src_a_o;
    o.alu_src_b = alu_src_b_o; o.alu_op = alu_op_o;               o.fault = fault_o;
    return o;
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] drv,
                      input logic [5:0] op, input bit rm);
    step_t s;
    s.st = st; s.rdy = rdy; s.drv_op = drv; s.op = op; s.rst_mid = rm;
    q.push_back(s);
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  // A memory wait of w not-ready cycles: completes on ready, or traps after TO misses.
  task automatic mem_wait(input logic [3:0] st, input int w, input logic [5:0] op, output bit halted);
    halted = (w >= TO);
    if (halted) begin
      repeat (TO) push(st, 1'b0, junk(), op, 1'b0);
    end else begin
      repeat (w) push(st, 1'b0, junk(), op, 1'b0);
      push(st, 1'b1, junk(), op, 1'b0);
    end
  endtask

  // Expected state trace for one instruction; opcode_i carries the real opcode only in DECODE.
  task automatic build_instr(input logic [5:0] op, input int wf, input int wm, input bit rst_in_wr);
    bit h;
    mem_wait(FETCH, wf, op, h);
    if (!h) begin
      push(DECODE, 1'($urandom), op, op, 1'b0);
      case (op)
        6'h00: begin push(REXE, 1'($urandom), junk(), op, 1'b0); push(RWB, 1'($urandom), junk(), op, 1'b0); end
        6'h23: begin
          push(MEMADR, 1'($urandom), junk(), op, 1'b0);
          mem_wait(MEMRD, wm, op, h);
          if (!h) push(MEMWB, 1'($urandom), junk(), op, 1'b0);
        end
        6'h2B: begin
          push(MEMADR, 1'($urandom), junk(), op, 1'b0);
          if (rst_in_wr) push(MEMWR, 1'b0, junk(), op, 1'b1);
          else           mem_wait(MEMWR, wm, op, h);
        end
        6'h04, 6'h05: push(BRANCH, 1'($urandom), junk(), op, 1'b0);
        6'h02:        push(JUMP, 1'($urandom), junk(), op, 1'b0);
        6'h08, 6'h0A: begin push(IEXE, 1'($urandom), junk(), op, 1'b0); push(IWB, 1'($urandom), junk(), op, 1'b0); end
        default:      h = 1'b1;
      endcase
    end
    if (h) begin
      push(HALT, 1'($urandom), junk(), op, 1'b0);
      push(HALT, 1'b1, junk(), op, 1'b0);
      push(HALT, 1'($urandom), junk(), op, 1'b1);
    end
  endtask

  // Entered and left on a falling edge; each step drives, settles 1 time unit, then compares.
  task automatic run_q();
    step_t s;
    out_t  o, e;
    while (q.size() > 0) begin
      s = q.pop_front();
      opcode_i    = s.drv_op;
      mem_ready_i = s.rdy;
      #1;
      o = obs();
      e = exp_out(s.st, s.rdy, s.op);
      check("state", 32'(state_o), 32'(s.st));
      check("outs", 32'(o), 32'(e));
      if (s.rst_mid) begin
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        #1;
        o = obs();
        e = exp_out(FETCH, 1'b0, 6'h00);
        check("async_rst_state", 32'(state_o), 32'(FETCH));
        check("async_rst_outs", 32'(o), 32'(e));
        q.delete();
      end
      @(negedge clk_i);
      rst_i = 1'b0;
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 15) == 0) return TO + int'($urandom_range(0, 2));
    return int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [10];
    logic [5:0] op;
    out_t       o;
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h23, 6'h00};

    rst_i = 1'b1; mem_ready_i = 1'b0; opcode_i = 6'h00;
    @(negedge clk_i); @(negedge clk_i);
    #1;
    o = obs();
    check("reset_state", 32'(state_o), 32'(FETCH));
    check("reset_outs", 32'(o), 32'(exp_out(FETCH, 1'b0, 6'h00)));
    @(negedge clk_i);
    rst_i = 1'b0;

    build_instr(6'h00, 0, 0, 1'b0); run_q();   // R-type, zero-wait
    build_instr(6'h23, 0, 3, 1'b0); run_q();   // lw, MEMRD held 4 cycles
    build_instr(6'h04, 1, 0, 1'b0); run_q();   // beq
    build_instr(6'h05, 0, 0, 1'b0); run_q();   // bne
    build_instr(6'h08, 2, 0, 1'b0); run_q();   // addi
    build_instr(6'h0A, 0, 0, 1'b0); run_q();   // slti
    build_instr(6'h02, 3, 0, 1'b0); run_q();   // j, longest legal fetch wait
    build_instr(6'h3F, 0, 0, 1'b0); run_q();   // illegal -> HALT, then reset
    build_instr(6'h00, TO, 0, 1'b0); run_q();  // fetch timeout straight after reset
    build_instr(6'h2B, 0, 3, 1'b0); run_q();   // sw
    build_instr(6'h23, 0, TO, 1'b0); run_q();  // lw read timeout
    build_instr(6'h2B, 1, 2, 1'b1); run_q();   // reset pulsed during MEMWR

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else                           op = legal[$urandom_range(0, 9)];
      build_instr(op, pick_wait(), pick_wait(), ($urandom_range(0, 19) == 0));
      run_q();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
